// File: rtl/ats_eligibility_requester.sv
// Per-frame ATS token-bucket eligibility engine: looks up flow state in the
// flow entry manager, computes the eligibility time, and writes back accepted state.
module ats_eligibility_requester #(
    parameter int TIME_WIDTH    = 59,
    parameter int LEN_WIDTH     = 16,
    parameter int MATCH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_flow_id,
    input  logic [3:0]            in_group_id,
    input  logic [LEN_WIDTH-1:0]  in_frame_length,
    input  logic [TIME_WIDTH-1:0] in_arrival_time,
    output logic [31:0]           flow_id,
    output logic [3:0]            group_id,
    output logic                  start_match_flag,
    output logic                  update_flag,
    output logic [TIME_WIDTH-1:0] update_bucket_empty_time,
    output logic [TIME_WIDTH-1:0] update_group_eligibility_time,
    input  logic                  match_finish_flag,
    input  logic [31:0]           bucket_size,
    input  logic [31:0]           token_rate,
    input  logic [TIME_WIDTH-1:0] bucket_empty_time,
    input  logic [TIME_WIDTH-1:0] group_eligibility_time,
    input  logic [TIME_WIDTH-1:0] max_residence_time,
    output logic                  out_valid,
    output logic [TIME_WIDTH-1:0] out_eligibility_time,
    output logic                  out_discard,
    output logic                  out_timeout
);

    localparam int CNT_W = $clog2(MATCH_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT_MATCH, S_CALC1, S_CALC2,
        S_WAIT_RELEASE, S_UPDATE, S_COOL1, S_COOL2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              latch_in, latch_mgr, do_calc1, do_calc2, do_update, do_out, do_timeout;

    logic [LEN_WIDTH-1:0]  len_reg;
    logic [TIME_WIDTH-1:0] arr_reg;
    logic [31:0]           bucket_reg, rate_reg;
    logic [TIME_WIDTH-1:0] bet_reg, get_reg, mrt_reg;
    logic [TIME_WIDTH-1:0] set_reg, bft_reg;
    logic [TIME_WIDTH-1:0] et_reg, new_bet_reg;
    logic                  accept_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_in   = 1'b0;
        latch_mgr  = 1'b0;
        do_calc1   = 1'b0;
        do_calc2   = 1'b0;
        do_update  = 1'b0;
        do_out     = 1'b0;
        do_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    latch_in   = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                cnt_next   = '0;
                state_next = S_WAIT_MATCH;
            end
            S_WAIT_MATCH: begin
                if (match_finish_flag) begin
                    latch_mgr  = 1'b1;
                    state_next = S_CALC1;
                end else if (cnt_reg == CNT_W'(MATCH_TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CALC1: begin
                do_calc1   = 1'b1;
                state_next = S_CALC2;
            end
            S_CALC2: begin
                do_calc2   = 1'b1;
                state_next = S_WAIT_RELEASE;
            end
            // The manager keeps match_finish_flag up for two cycles; write back only once it drops.
            S_WAIT_RELEASE: begin
                if (!match_finish_flag) begin
                    do_update  = 1'b1;
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: state_next = S_COOL1;
            S_COOL1:  state_next = S_COOL2;
            S_COOL2: begin
                do_out     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready         = (state_reg == S_IDLE) && !reset;
    assign start_match_flag = (state_reg == S_REQ);

    // Products are 48-bit by definition, so the upper bits of bucket*rate are dropped.
    logic [47:0]           lrd, e2f;
    logic [TIME_WIDTH-1:0] et_base, et_c, mrt_limit, new_bet_c;
    logic                  accept_c;

    assign lrd       = 48'(len_reg) * 48'(rate_reg);
    assign e2f       = 48'(bucket_reg) * 48'(rate_reg);
    assign et_base   = (arr_reg > get_reg) ? arr_reg : get_reg;
    assign et_c      = (set_reg > et_base) ? set_reg : et_base;
    assign mrt_limit = arr_reg + mrt_reg;
    assign accept_c  = (mrt_reg == '0) || (et_c <= mrt_limit);
    assign new_bet_c = (et_c < bft_reg) ? set_reg : (set_reg + et_c - bft_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg                       <= '0;
            arr_reg                       <= '0;
            flow_id                       <= '0;
            group_id                      <= '0;
            bucket_reg                    <= '0;
            rate_reg                      <= '0;
            bet_reg                       <= '0;
            get_reg                       <= '0;
            mrt_reg                       <= '0;
            set_reg                       <= '0;
            bft_reg                       <= '0;
            et_reg                        <= '0;
            new_bet_reg                   <= '0;
            accept_reg                    <= 1'b0;
            update_flag                   <= 1'b0;
            update_bucket_empty_time      <= '0;
            update_group_eligibility_time <= '0;
            out_valid                     <= 1'b0;
            out_eligibility_time          <= '0;
            out_discard                   <= 1'b0;
            out_timeout                   <= 1'b0;
        end else begin
            update_flag <= 1'b0;
            out_valid   <= 1'b0;
            if (latch_in) begin
                len_reg  <= in_frame_length;
                arr_reg  <= in_arrival_time;
                flow_id  <= in_flow_id;
                group_id <= in_group_id;
            end
            if (latch_mgr) begin
                bucket_reg <= bucket_size;
                rate_reg   <= token_rate;
                bet_reg    <= bucket_empty_time;
                get_reg    <= group_eligibility_time;
                mrt_reg    <= max_residence_time;
            end
            if (do_calc1) begin
                set_reg <= bet_reg + TIME_WIDTH'(lrd);
                bft_reg <= bet_reg + TIME_WIDTH'(e2f);
            end
            if (do_calc2) begin
                et_reg      <= et_c;
                accept_reg  <= accept_c;
                new_bet_reg <= new_bet_c;
            end
            // Rejected frames leave the stored flow and group state untouched.
            if (do_update && accept_reg) begin
                update_flag                   <= 1'b1;
                update_bucket_empty_time      <= new_bet_reg;
                update_group_eligibility_time <= et_reg;
            end
            if (do_out) begin
                out_valid            <= 1'b1;
                out_eligibility_time <= et_reg;
                out_discard          <= !accept_reg;
                out_timeout          <= 1'b0;
            end else if (do_timeout) begin
                out_valid            <= 1'b1;
                out_eligibility_time <= '0;
                out_discard          <= 1'b1;
                out_timeout          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ats_eligibility_requester.sv
// Bench for ats_eligibility_requester: table vectors, randomized frames against a
// token-bucket reference model, timeout, busy back-pressure and mid-frame reset.
module tb_ats_eligibility_requester;

    localparam int TW = 59;
    localparam longint unsigned MASK59 = (64'd1 << 59) - 64'd1;
    localparam longint unsigned MASK48 = (64'd1 << 48) - 64'd1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_flow_id = '0;
    logic [3:0]    in_group_id = '0;
    logic [15:0]   in_frame_length = '0;
    logic [TW-1:0] in_arrival_time = '0;
    logic [31:0]   flow_id;
    logic [3:0]    group_id;
    logic          start_match_flag, update_flag;
    logic [TW-1:0] update_bucket_empty_time, update_group_eligibility_time;
    logic          match_finish_flag = 1'b0;
    logic [31:0]   bucket_size = '0, token_rate = '0;
    logic [TW-1:0] bucket_empty_time = '0, group_eligibility_time = '0, max_residence_time = '0;
    logic          out_valid;
    logic [TW-1:0] out_eligibility_time;
    logic          out_discard, out_timeout;

    ats_eligibility_requester dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_flow_id(in_flow_id), .in_group_id(in_group_id),
        .in_frame_length(in_frame_length), .in_arrival_time(in_arrival_time),
        .flow_id(flow_id), .group_id(group_id),
        .start_match_flag(start_match_flag), .update_flag(update_flag),
        .update_bucket_empty_time(update_bucket_empty_time),
        .update_group_eligibility_time(update_group_eligibility_time),
        .match_finish_flag(match_finish_flag),
        .bucket_size(bucket_size), .token_rate(token_rate),
        .bucket_empty_time(bucket_empty_time),
        .group_eligibility_time(group_eligibility_time),
        .max_residence_time(max_residence_time),
        .out_valid(out_valid), .out_eligibility_time(out_eligibility_time),
        .out_discard(out_discard), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     flow;
        logic [3:0]      grp;
        longint unsigned len, arr, bucket, rate, bet, get, mrt;
    } frame_t;

    typedef struct {
        longint unsigned et, nbet, nget;
        bit              disc, upd;
    } exp_t;

    typedef struct {
        frame_t f;
        exp_t   e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    frame_t cur;
    int     mgr_lat = 1;
    bit     mgr_en = 1'b0;

    int              smf_cnt, upd_cnt, ov_cnt, smf_cyc, upd_cyc, ov_cyc;
    logic [31:0]     cap_flow;
    logic [3:0]      cap_grp;
    longint unsigned cap_ubet, cap_uget, cap_et;
    bit              cap_disc, cap_to;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (start_match_flag) begin
            smf_cnt++; smf_cyc = cyc; cap_flow = flow_id; cap_grp = group_id;
        end
        if (update_flag) begin
            upd_cnt++; upd_cyc = cyc;
            cap_ubet = 64'(update_bucket_empty_time);
            cap_uget = 64'(update_group_eligibility_time);
        end
        if (out_valid) begin
            ov_cnt++; ov_cyc = cyc;
            cap_et = 64'(out_eligibility_time); cap_disc = out_discard; cap_to = out_timeout;
        end
    end

    // Flow entry manager stand-in: answers a lookup after mgr_lat cycles, flag high for 2 cycles.
    always begin
        @(negedge clk);
        if (start_match_flag && mgr_en) begin
            repeat (mgr_lat) @(negedge clk);
            bucket_size            = 32'(cur.bucket);
            token_rate             = 32'(cur.rate);
            bucket_empty_time      = TW'(cur.bet);
            group_eligibility_time = TW'(cur.get);
            max_residence_time     = TW'(cur.mrt);
            match_finish_flag      = 1'b1;
            repeat (2) @(negedge clk);
            match_finish_flag = 1'b0;
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input frame_t f);
        exp_t e;
        longint unsigned lrd, e2f, set_t, bft, et, lim;
        lrd   = (f.len * f.rate) & MASK48;
        e2f   = (f.bucket * f.rate) & MASK48;
        set_t = (f.bet + lrd) & MASK59;
        bft   = (f.bet + e2f) & MASK59;
        et    = f.arr;
        if (f.get > et) et = f.get;
        if (set_t > et) et = set_t;
        lim    = (f.arr + f.mrt) & MASK59;
        e.et   = et;
        e.upd  = (f.mrt == 0) || (et <= lim);
        e.disc = !e.upd;
        e.nbet = (et < bft) ? set_t : ((set_t + et - bft) & MASK59);
        e.nget = et;
        return e;
    endfunction

    task automatic clear_counts();
        smf_cnt = 0; upd_cnt = 0; ov_cnt = 0;
    endtask

    task automatic present(input frame_t f);
        in_flow_id      = f.flow;
        in_group_id     = f.grp;
        in_frame_length = 16'(f.len);
        in_arrival_time = TW'(f.arr);
        in_valid        = 1'b1;
    endtask

    // Waits until ov_cnt reaches target; flags in_ready seen high while busy.
    task automatic wait_out(input int target, input string tag);
        bit busy_bad = 1'b0;
        int n = 0;
        while (ov_cnt < target && n < 300) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_out_valid_seen"}, 64'(ov_cnt), 64'(target));
        chk({tag, "_in_ready_low_while_busy"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic run_frame(input frame_t f, input exp_t e, input bit timeout_case, input int tag_n);
        string tag;
        tag = $sformatf("frame%0d", tag_n);
        cur = f; mgr_en = !timeout_case; mgr_lat = $urandom_range(1, 4);
        clear_counts();
        present(f);
        @(negedge clk); #1;
        in_valid = 1'b0;
        wait_out(1, tag);
        chk({tag, "_start_pulses"}, 64'(smf_cnt), 64'd1);
        chk({tag, "_flow_id"}, 64'(cap_flow), 64'(f.flow));
        chk({tag, "_group_id"}, 64'(cap_grp), 64'(f.grp));
        chk({tag, "_et"}, cap_et, timeout_case ? 64'd0 : e.et);
        chk({tag, "_discard"}, 64'(cap_disc), timeout_case ? 64'd1 : 64'(e.disc));
        chk({tag, "_timeout"}, 64'(cap_to), 64'(timeout_case));
        chk({tag, "_update_pulses"}, 64'(upd_cnt), (e.upd && !timeout_case) ? 64'd1 : 64'd0);
        if (e.upd && !timeout_case) begin
            chk({tag, "_upd_bet"}, cap_ubet, e.nbet);
            chk({tag, "_upd_get"}, cap_uget, e.nget);
            chk({tag, "_upd_to_out_gap"}, 64'(ov_cyc - upd_cyc), 64'd3);
        end
        if (timeout_case) chk({tag, "_timeout_latency"}, 64'(ov_cyc - smf_cyc), 64'd65);
        $display("frame %0d flow=%h grp=%0d et=%0d discard=%0b timeout=%0b updates=%0d",
                 tag_n, f.flow, f.grp, cap_et, cap_disc, cap_to, upd_cnt);
        @(negedge clk); #1;
    endtask

    function automatic frame_t mk(input longint unsigned len, arr, bucket, rate, bet, get, mrt);
        frame_t f;
        f.flow = 32'h100 + 32'(len[7:0]); f.grp = 4'd3;
        f.len = len; f.arr = arr; f.bucket = bucket; f.rate = rate;
        f.bet = bet; f.get = get; f.mrt = mrt;
        return f;
    endfunction

    function automatic exp_t mke(input longint unsigned et, nbet, nget, input bit upd);
        exp_t e;
        e.et = et; e.nbet = nbet; e.nget = nget; e.upd = upd; e.disc = !upd;
        return e;
    endfunction

    vec_t   table_v[4];
    frame_t rf, fa, fb;
    exp_t   re;

    initial begin
        table_v[0].f = mk(1000, 1000,   3200, 8, 0,     0,     0);
        table_v[0].e = mke(8000, 8000, 8000, 1'b1);
        table_v[1].f = mk(1000, 100000, 3200, 8, 0,     0,     0);
        table_v[1].e = mke(100000, 82400, 100000, 1'b1);
        table_v[2].f = mk(100,  1000,   3200, 8, 0,     20000, 0);
        table_v[2].e = mke(20000, 800, 20000, 1'b1);
        table_v[3].f = mk(100,  1000,   3200, 8, 50000, 0,     5000);
        table_v[3].e = mke(50800, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_flow_id", 64'(flow_id), 64'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 4; i++) run_frame(table_v[i].f, table_v[i].e, 1'b0, i);

        for (int i = 0; i < 30; i++) begin
            rf.flow   = $urandom;
            rf.grp    = 4'($urandom_range(0, 11));
            rf.len    = $urandom_range(64, 1500);
            rf.rate   = (i % 5 == 0) ? longint'($urandom) : longint'($urandom_range(1, 1000));
            rf.bucket = (i % 5 == 0) ? longint'($urandom) : longint'($urandom_range(0, 200000));
            rf.arr    = ((longint'($urandom) << 8) | longint'($urandom_range(0, 255))) & MASK59;
            rf.bet    = (rf.arr + longint'($urandom_range(0, 1000000)) - 64'd500000) & MASK59;
            rf.get    = (rf.arr + longint'($urandom_range(0, 1000000)) - 64'd500000) & MASK59;
            if (i % 7 == 0) rf.bet = MASK59 - longint'($urandom_range(0, 1000));
            rf.mrt    = ($urandom_range(0, 3) == 0) ? 64'd0 : longint'($urandom_range(1, 2000000));
            re = model(rf);
            run_frame(rf, re, 1'b0, 10 + i);
        end

        rf = mk(500, 7777, 100, 2, 0, 0, 0);
        re = model(rf);
        run_frame(rf, re, 1'b1, 99);

        // Second descriptor held while busy must wait for the first result.
        fa = mk(200, 5000, 3200, 8, 0, 0, 0); fa.flow = 32'hAAAA_0001;
        fb = fa; fb.flow = 32'hBBBB_0002; fb.grp = 4'd11;
        cur = fa; mgr_en = 1'b1; mgr_lat = 2;
        clear_counts();
        present(fa);
        @(negedge clk); #1;
        present(fb);
        wait_out(1, "busy_first");
        chk("busy_starts_before_release", 64'(smf_cnt), 64'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        wait_out(2, "busy_second");
        chk("busy_second_started", 64'(smf_cnt), 64'd2);
        chk("busy_second_flow", 64'(cap_flow), 64'(fb.flow));
        chk("busy_second_group", 64'(cap_grp), 64'(fb.grp));
        $display("busy pair flows=%h,%h outputs=%0d", fa.flow, fb.flow, ov_cnt);
        @(negedge clk); #1;

        // Reset while waiting for the manager aborts the frame silently.
        mgr_en = 1'b0;
        clear_counts();
        present(fa);
        @(negedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'd0);
        chk("midreset_start", 64'(start_match_flag), 64'd0);
        chk("midreset_flow_id", 64'(flow_id), 64'd0);
        chk("midreset_upd_bet", 64'(update_bucket_empty_time), 64'd0);
        chk("midreset_out_et", 64'(out_eligibility_time), 64'd0);
        chk("midreset_discard", 64'(out_discard), 64'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        chk("midreset_no_out_valid", 64'(ov_cnt), 64'd0);
        chk("midreset_no_update", 64'(upd_cnt), 64'd0);
        chk("midreset_idle_ready", 64'(in_ready), 64'd1);
        $display("mid-frame reset: outputs=%0d updates=%0d", ov_cnt, upd_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
